// File: rtl/sd_text_scanner.sv
// Finds TAG in consecutive SD blocks from START_BLOCK, then counts delimited WORD hits up to END_MARK (SCAN_CASE_FOLD_EN folds A-Z in the word compare).
// Latency: (2 + 512) cycles per block scanned + CNT_W + 2 with init_finished high and continuous sd_valid.
// Backpressure: none; every sd_valid byte in READ is consumed, and start is ignored while busy.
module sd_text_scanner #(
  parameter logic [31:0] START_BLOCK = 32'h2000,
  parameter int          MAX_BLOCKS  = 1024,
  parameter logic [63:0] TAG         = 64'h444C_4142_5F54_4147,
  parameter logic [63:0] WORD        = 64'h0000_0000_0074_6865,
  parameter int          WORD_LEN    = 3,
  parameter logic [63:0] END_MARK    = 64'h0000_0000_0045_4E44,
  parameter int          END_LEN     = 3,
  parameter int          CNT_W       = 10,
  parameter int          BCD_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    init_finished,
  output logic                    rd_req,
  output logic [31:0]             block_addr,
  input  logic [7:0]              sd_dout,
  input  logic                    sd_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    tag_found,
  output logic                    err,
  output logic                    ovf,
  output logic [CNT_W-1:0]        match_count,
  output logic [4*BCD_DIGITS-1:0] match_bcd
);

  localparam int                BCD_W    = 4 * BCD_DIGITS;
  localparam int                BW       = $clog2(CNT_W + 1);
  localparam logic [BW-1:0]     BIT_LAST = BW'(CNT_W - 1);
  localparam logic [63:0]       END_MASK = {64{1'b1}} >> (64 - 8 * END_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, WAIT_INIT, REQ, READ, NEXT, BCD, FIN} state_t;

  state_t            state, state_nxt;
  logic [63:0]       win, win_nxt;
  logic [9:0]        byte_cnt;
  logic [31:0]       blk_idx;
  logic              end_seen;
  logic [CNT_W-1:0]  bin_sh;
  logic [BW-1:0]     bit_cnt;
  logic [BCD_W-1:0]  bcd_sh, bcd_adj;
  logic              take, last_blk;
  logic              tag_hit, word_hit, end_hit;

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef SCAN_CASE_FOLD_EN
    fold = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
`else
    fold = b;
`endif
  endfunction

  function automatic logic is_delim(input logic [7:0] b);
    is_delim = (b == 8'h20) || (b == 8'h0A);
  endfunction

  assign take       = (state == READ) && sd_valid;
  assign last_blk   = (blk_idx + 32'd1 == 32'(MAX_BLOCKS));
  assign win_nxt    = {win[55:0], sd_dout};
  assign block_addr = START_BLOCK + blk_idx;
  assign match_bcd  = bcd_sh;

  // All matches look at the window including the byte being accepted this cycle.
  always_comb begin
    tag_hit  = (win_nxt == TAG);
    end_hit  = ((win_nxt & END_MASK) == (END_MARK & END_MASK));
    word_hit = is_delim(win_nxt[7:0]) && is_delim(win_nxt[8*WORD_LEN+8 +: 8]);
    for (int i = 0; i < WORD_LEN; i++)
      if (fold(win_nxt[8*i+8 +: 8]) != fold(WORD[8*i +: 8])) word_hit = 1'b0;
  end

  always_comb begin
    bcd_adj = bcd_sh;
    for (int d = 0; d < BCD_DIGITS; d++)
      if (bcd_sh[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = WAIT_INIT;
      end
      WAIT_INIT: if (init_finished) state_nxt = REQ;
      REQ: begin
        rd_req    = 1'b1;
        state_nxt = READ;
      end
      READ: if (take && byte_cnt == 10'd511) state_nxt = NEXT;
      NEXT: state_nxt = (end_seen || last_blk) ? BCD : REQ;
      BCD:  if (bit_cnt == BIT_LAST) state_nxt = FIN;
      FIN: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win         <= '0;
      byte_cnt    <= '0;
      blk_idx     <= '0;
      end_seen    <= 1'b0;
      tag_found   <= 1'b0;
      err         <= 1'b0;
      ovf         <= 1'b0;
      match_count <= '0;
      bin_sh      <= '0;
      bit_cnt     <= '0;
      bcd_sh      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          win         <= '0;
          blk_idx     <= '0;
          end_seen    <= 1'b0;
          tag_found   <= 1'b0;
          err         <= 1'b0;
          ovf         <= 1'b0;
          match_count <= '0;
          bcd_sh      <= '0;
        end
        REQ: byte_cnt <= '0;
        READ: if (take) begin
          win      <= win_nxt;
          byte_cnt <= byte_cnt + 10'd1;
          // Once END_MARK is seen the rest of the block is only drained.
          if (!end_seen) begin
            if (!tag_found) begin
              if (tag_hit) tag_found <= 1'b1;
            end else begin
              if (word_hit) begin
                if (match_count == CNT_MAX) ovf <= 1'b1;
                else                        match_count <= match_count + CNT_W'(1);
              end
              if (end_hit) end_seen <= 1'b1;
            end
          end
        end
        NEXT: begin
          if (end_seen || last_blk) begin
            err     <= !end_seen;
            bin_sh  <= match_count;
            bcd_sh  <= '0;
            bit_cnt <= '0;
          end else begin
            blk_idx <= blk_idx + 32'd1;
          end
        end
        BCD: begin
          bcd_sh  <= {bcd_adj[BCD_W-2:0], bin_sh[CNT_W-1]};
          bin_sh  <= bin_sh << 1;
          bit_cnt <= bit_cnt + BW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_text_scanner.sv
// Bench for sd_text_scanner: an SD block responder serves a byte image; results are compared
// against a string-search reference model, on a default-width instance and a 4-bit-counter instance.
module tb_sd_text_scanner;

  localparam int NBLK = 4;
  localparam int IMG  = NBLK * 512;

  logic        clk = 1'b0;
  logic        reset_n, start, init_finished, sd_valid;
  logic [7:0]  sd_dout;

  logic        rd_req, busy, done, tag_found, err, ovf;
  logic [31:0] block_addr;
  logic [9:0]  match_count;
  logic [15:0] match_bcd;

  logic        sat_rd_req, sat_busy, sat_done, sat_tag_found, sat_err, sat_ovf;
  logic [31:0] sat_block_addr;
  logic [3:0]  sat_match_count;
  logic [15:0] sat_match_bcd;

  logic [7:0]  img [0:IMG-1];
  logic [31:0] addr_q [$];
  int          n_asserts = 0;
  int          n_fail = 0;
  int          sat_reads = 0;
  int          rsp_base;
  bit          gap_en = 1'b0;

  always #5 clk = ~clk;

  sd_text_scanner #(.MAX_BLOCKS(NBLK)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .init_finished(init_finished),
    .rd_req(rd_req), .block_addr(block_addr), .sd_dout(sd_dout), .sd_valid(sd_valid),
    .busy(busy), .done(done), .tag_found(tag_found), .err(err), .ovf(ovf),
    .match_count(match_count), .match_bcd(match_bcd)
  );

  sd_text_scanner #(.MAX_BLOCKS(NBLK), .CNT_W(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .init_finished(init_finished),
    .rd_req(sat_rd_req), .block_addr(sat_block_addr), .sd_dout(sd_dout), .sd_valid(sd_valid),
    .busy(sat_busy), .done(sat_done), .tag_found(sat_tag_found), .err(sat_err), .ovf(sat_ovf),
    .match_count(sat_match_count), .match_bcd(sat_match_bcd)
  );

  always @(posedge clk) if (sat_rd_req) sat_reads++;

  // SD card model: one cycle after a request, stream the 512 bytes of that block.
  initial begin
    sd_valid = 1'b0;
    sd_dout  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rd_req && reset_n) begin
        addr_q.push_back(block_addr);
        rsp_base = (int'(block_addr) - 32'h2000) * 512;
        @(posedge clk); #1;
        for (int i = 0; i < 512 && reset_n; i++) begin
          if (gap_en)
            while ($urandom_range(0, 3) == 0 && reset_n) begin
              sd_valid = 1'b0;
              @(posedge clk); #1;
            end
          sd_valid = 1'b1;
          sd_dout  = (rsp_base + i >= 0 && rsp_base + i < IMG) ? img[rsp_base + i] : 8'h2E;
          @(posedge clk); #1;
        end
        sd_valid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lc(input logic [7:0] b);
`ifdef SCAN_CASE_FOLD_EN
    return (b >= 8'h41 && b <= 8'h5A) ? b + 8'd32 : b;
`else
    return b;
`endif
  endfunction

  function automatic bit is_d(input logic [7:0] b);
    return b == 8'h20 || b == 8'h0A;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: plain string search over the whole image.
  task automatic model(output int cnt, output bit tagf, output bit errf, output int nblk);
    string tg = "DLAB_TAG";
    string wd = "the";
    string em = "END";
    int    tpos = -1;
    int    epos = -1;
    bit    ok;
    cnt = 0;
    for (int i = 7; i < IMG && tpos < 0; i++) begin
      ok = 1'b1;
      for (int k = 0; k < 8; k++) if (img[i-7+k] != tg[k]) ok = 1'b0;
      if (ok) tpos = i;
    end
    if (tpos >= 0)
      for (int i = tpos + 1; i < IMG && epos < 0; i++) begin
        ok = is_d(img[i]) && is_d(img[i-4]);
        for (int k = 0; k < 3; k++) if (lc(img[i-3+k]) != lc(wd[k])) ok = 1'b0;
        if (ok) cnt++;
        ok = 1'b1;
        for (int k = 0; k < 3; k++) if (img[i-2+k] != em[k]) ok = 1'b0;
        if (ok) epos = i;
      end
    tagf = (tpos >= 0);
    errf = (epos < 0);
    nblk = errf ? NBLK : epos / 512 + 1;
  endtask

  task automatic fill(input logic [7:0] c);
    for (int i = 0; i < IMG; i++) img[i] = c;
  endtask

  task automatic put(input int pos, input string s);
    for (int i = 0; i < s.len(); i++) img[pos+i] = s[i];
  endtask

  task automatic run_scan(input string nm, input bit poke, input int init_delay);
    int cnt, nblk, n, sat_exp, addr_base, sat_base;
    bit tagf, errf, sat_done_seen;
    model(cnt, tagf, errf, nblk);
    sat_exp       = (cnt > 15) ? 15 : cnt;
    addr_base     = addr_q.size();
    sat_base      = sat_reads;
    sat_done_seen = 1'b0;
    init_finished = (init_delay == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 8000) begin
      if (init_delay > 0 && n == init_delay) begin
        check({nm, "/wait_busy"}, busy, 1);
        check({nm, "/wait_noreq"}, addr_q.size() - addr_base, 0);
        init_finished = 1'b1;
      end
      start = poke && (n == 300);
      if (sat_done) sat_done_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({nm, "/no_timeout"}, n < 8000, 1);
    if (!gap_en && init_delay == 0) check({nm, "/latency"}, n + 1, 514 * nblk + 12);
    @(posedge clk); #1;
    check({nm, "/done_pulse"}, done, 0);
    check({nm, "/idle_busy"}, busy, 0);
    check({nm, "/count"}, match_count, cnt);
    check({nm, "/bcd"}, match_bcd, to_bcd(cnt));
    check({nm, "/tag"}, tag_found, tagf);
    check({nm, "/err"}, err, errf);
    check({nm, "/ovf"}, ovf, cnt > 1023);
    check({nm, "/reads"}, addr_q.size() - addr_base, nblk);
    for (int k = 0; k < nblk && addr_base + k < addr_q.size(); k++)
      check({nm, "/addr"}, addr_q[addr_base + k], 32'h2000 + k);
    check({nm, "/sat_done"}, sat_done_seen, 1);
    check({nm, "/sat_count"}, sat_match_count, sat_exp);
    check({nm, "/sat_bcd"}, sat_match_bcd, to_bcd(sat_exp));
    check({nm, "/sat_ovf"}, sat_ovf, cnt > 15);
    check({nm, "/sat_tag"}, sat_tag_found, tagf);
    check({nm, "/sat_err"}, sat_err, errf);
    check({nm, "/sat_reads"}, sat_reads - sat_base, nblk);
    check({nm, "/sat_addr"}, sat_block_addr, block_addr);
  endtask

  initial begin
    string alpha = "the THE\nxEN.D";
    reset_n       = 1'b0;
    start         = 1'b0;
    init_finished = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/rd_req", rd_req, 0);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/flags", {tag_found, err, ovf}, 0);
    check("rst/count", match_count, 0);
    check("rst/bcd", match_bcd, 0);
    check("rst/addr", block_addr, 32'h2000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single block, two matches, exact latency.
    fill(8'h2E);
    put(0, "xxDLAB_TAG the cat the\nEND");
    run_scan("one_block", 0, 0);

    // TAG straddling blocks 0/1, words in block 2, END in block 3; extra start while busy.
    fill(8'h2E);
    put(508, "DLAB");
    put(512, "_TAG");
    put(1024, " the the x the\n");
    put(1546, "END");
    gap_en = 1'b1;
    run_scan("split_tag", 1, 0);

    // Mixed case words, with init_finished held low for a while.
    fill(8'h2E);
    put(0, "DLAB_TAG The THE the END");
    gap_en = 1'b0;
    run_scan("case", 0, 20);

    // No END_MARK: all blocks read, err set.
    fill(8'h2E);
    put(100, "DLAB_TAG the ");
    put(700, " the\n");
    run_scan("no_end", 0, 0);

    // Twenty matches saturate the 4-bit instance.
    fill(8'h2E);
    put(0, "DLAB_TAG");
    for (int k = 0; k < 20; k++) put(8 + 4 * k, " the");
    put(88, " END");
    run_scan("saturate", 0, 0);

    // Reset while reading block 1 with a count already accumulated.
    fill(8'h2E);
    put(0, "DLAB_TAG the the the ");
    put(1700, "END");
    init_finished = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (700) begin @(posedge clk); #1; end
    check("midrst/busy_before", busy, 1);
    check("midrst/addr_before", block_addr, 32'h2001);
    reset_n = 1'b0;
    #1;
    check("midrst/rd_req", rd_req, 0);
    check("midrst/busy", busy, 0);
    check("midrst/count", match_count, 0);
    check("midrst/tag", tag_found, 0);
    check("midrst/addr", block_addr, 32'h2000);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    fill(8'h2E);
    put(0, "xxDLAB_TAG the cat the\nEND");
    run_scan("after_rst", 0, 0);

    // Random images with a planted tag and planted words.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < IMG; i++) img[i] = alpha[$urandom_range(0, alpha.len() - 1)];
      put(int'($urandom_range(0, 1500)), "DLAB_TAG");
      for (int k = 0; k < 6; k++) put(int'($urandom_range(0, IMG - 8)), " the ");
      gap_en = 1'($urandom_range(0, 1));
      run_scan("random", 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_text_scanner.md
Name: sd_text_scanner

Overview:
- Streaming text-search engine between `sd_card` (byte stream side) and the top-level display logic.
- Walks consecutive 512-byte SD blocks starting at START_BLOCK and ignores all bytes until the start tag TAG has been seen.
- Then counts delimited, whole-word occurrences of WORD until the end mark END_MARK, and returns the count in binary and in BCD.
- Parametrised successor of the fixed single-pattern lab scanner: configurable patterns, block range, count width, overflow and error reporting.

Parameters:
- START_BLOCK, 32'h2000: first block address read.
- MAX_BLOCKS, 1024: scan limit; reaching it without END_MARK raises err.
- TAG, "DLAB_TAG": 64-bit start tag, exactly 8 bytes.
- WORD, "the": word pattern, right-aligned in 64 bits.
- WORD_LEN, 3: valid bytes of WORD, range 1..6.
- END_MARK, "END": end mark, right-aligned in 64 bits.
- END_LEN, 3: valid bytes of END_MARK, range 1..8.
- CNT_W, 10: match counter width.
- BCD_DIGITS, 4: number of BCD output digits; must satisfy 10^BCD_DIGITS > 2^CNT_W.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle pulse that begins a scan.
- init_finished, in, 1: SD controller ready.
- rd_req, out, 1: block read request to `sd_card`.
- block_addr, out, 32: block address to `sd_card`.
- sd_dout, in, 8: streamed data byte.
- sd_valid, in, 1: sd_dout qualifier.
- busy, out, 1: high from accepted start until done.
- done, out, 1: one-cycle completion pulse.
- tag_found, out, 1: TAG was seen during the scan.
- err, out, 1: END_MARK was not found within MAX_BLOCKS.
- ovf, out, 1: match counter saturated.
- match_count, out, CNT_W: binary match count.
- match_bcd, out, 4*BCD_DIGITS: BCD of match_count, most significant digit first.

Behaviour:
- Reset: asynchronous to IDLE. All outputs are 0; block_addr resets to START_BLOCK. Reset mid-read drops rd_req immediately; the following start begins again at START_BLOCK.
- States: IDLE, WAIT_INIT, REQ, READ, NEXT, BCD, FIN.
- IDLE: on start, clear the counter, window, flags and block index, then go to WAIT_INIT. start is ignored when not in IDLE.
- WAIT_INIT: go to REQ when init_finished=1; stay indefinitely otherwise.
- REQ: rd_req=1 for exactly one cycle; block_addr = START_BLOCK + blk_idx. Next state READ.
- READ:
  - Each sd_valid byte shifts into a 64-bit window (newest byte in [7:0]) and increments byte_cnt.
  - The window persists across blocks, so TAG, words and END_MARK may straddle a block boundary.
  - Bytes with sd_valid=0 are ignored.
  - When byte_cnt reaches 512, go to NEXT.
- Pattern checks are made on the window value that includes the newest byte, in the same cycle that byte is accepted:
  - Before tag_found: the window equals TAG → tag_found=1. No counting occurs on or before that byte.
  - After tag_found, word match: window bytes [WORD_LEN+1:0] = D, WORD, D, where each D is 8'h20 or 8'h0A. This increments the counter.
  - Overlap: a trailing delimiter also serves as the next leading delimiter, so "␠the␠the␠" counts 2.
  - After tag_found, end match: the low END_LEN bytes equal END_MARK → end_seen=1.
  - If a word match and the end match coincide on the same byte, the count is taken first.
- After end_seen: the remaining bytes of the current block are drained (counted toward 512) but not inspected.
- NEXT:
  - If end_seen, go to BCD.
  - Else if blk_idx+1 = MAX_BLOCKS, set err=1 and go to BCD.
  - Else increment blk_idx and go to REQ. blk_idx wraps never; it is bounded by MAX_BLOCKS.
- Counter: saturates at 2^CNT_W-1 and sets ovf=1; it never wraps.
- BCD: shift-add-3 (double dabble), one bit per cycle, CNT_W cycles. Then go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Output validity: match_count, match_bcd, tag_found, err and ovf are registered, valid from done, and held until the next accepted start.
- Latency from start to done, with init_finished=1 and continuous sd_valid: (2 + 512) per block scanned + CNT_W + 2 cycles.

Optional Feature:
- Macro: SCAN_CASE_FOLD_EN.
- Defined: the word comparison folds ASCII 'A'..'Z' to lower case in both window and WORD, so "The"/"THE" match "the". TAG and END_MARK are always compared exactly.
- Undefined: all comparisons are exact byte equality.

Test Plan:
- Block 0x2000 = "xxDLAB_TAG the cat the\nEND" (padding after): start → one block read, done, match_count=2, match_bcd=16'h0002, tag_found=1, err=0.
- TAG split across blocks 0x2000/0x2001 ("DLAB" | "_TAG"), word matches in 0x2002, END in 0x2003: start → 4 rd_req pulses at addresses 0x2000..0x2003, correct count.
- " The THE the " after TAG, then END: count=1 without SCAN_CASE_FOLD_EN, count=3 with it.
- MAX_BLOCKS=4, TAG present, no END: start → exactly 4 reads, done, err=1, count holds matches seen.
- CNT_W=4 with 20 matches → match_count=15, ovf=1, match_bcd=16'h0015.
- reset_n pulsed low mid-READ, then start → rd_req restarts at 0x2000, no stale count; a start pulse while busy has no effect.
